// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with occupancy count, EMPTY/PARTIAL/FULL status FSM and
// registered threshold/error flags. Define FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned AF_LVL = (1 << ADDR_W) - 1,
    parameter int unsigned AE_LVL = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LVL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LVL);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                af_q, af_d;
    logic                ae_q, ae_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                wr_acc;
    logic                rd_acc;

    // Acceptance is decided purely from the registered state, never from count arithmetic.
    assign wr_acc = wr_en_i && (state_q != ST_FULL);
    assign rd_acc = rd_en_i && (state_q != ST_EMPTY);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_EMPTY: begin
                if (wr_acc) state_d = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (wr_acc && !rd_acc && (count_q == CNT_LAST)) begin
                    state_d = ST_FULL;
                end else if (rd_acc && !wr_acc && (count_q == CNT_ONE)) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (rd_acc) state_d = ST_PARTIAL;
            end
            default: state_d = ST_EMPTY;
        endcase

        af_d  = (count_d >= AF_CNT);
        ae_d  = (count_d <= AE_CNT);
        ovf_d = wr_en_i && (state_q == ST_FULL);
        udf_d = rd_en_i && (state_q == ST_EMPTY);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage has no reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in_i;
    end

`ifdef FIFO_FWFT_EN
    assign data_out_o = mem_q[rd_ptr_q];
    assign valid_o    = (state_q != ST_EMPTY);
`else
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = rd_acc;
        if (rd_acc) data_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out_o = data_q;
    assign valid_o    = valid_q;
`endif

    assign full_o         = (state_q == ST_FULL);
    assign empty_o        = (state_q == ST_EMPTY);
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parameterised synchronous FIFO buffer with pointer/occupancy control and a registered status state machine. It replaces fixed 8x8 buffering wherever a stream must be decoupled between producer and consumer logic on a single clock. It accepts simultaneous read and write, reports almost-full/almost-empty thresholds, and flags overflow and underflow attempts. First-word-fall-through output is a compile option.

## Interface
- DATA_W, 8: data width in bits.
- ADDR_W, 3: address width; depth DEPTH = 2**ADDR_W entries (ADDR_W >= 1).
- AF_LVL, DEPTH-1: almost_full asserts when count >= AF_LVL.
- AE_LVL, 1: almost_empty asserts when count <= AE_LVL.

- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request.
- data_in  input  DATA_W  write data, sampled with wr_en.
- rd_en  input  1  read request.
- data_out  output  DATA_W  read data.
- valid  output  1  data_out holds a newly read word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LVL.
- almost_empty  output  1  count <= AE_LVL.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write attempted while full.
- underflow  output  1  one-cycle pulse: read attempted while empty.

## Operation
- Write accepted iff wr_en && !full; read accepted iff rd_en && !empty; flags are sampled from the registered state before the edge.
- Accepted write: mem[wr_ptr] <= data_in, wr_ptr increments. Accepted read: data_out <= mem[rd_ptr], rd_ptr increments.
- Pointers are ADDR_W bits and wrap modulo DEPTH with no special case. count is ADDR_W+1 bits: +1 on write only, -1 on read only, unchanged on both or neither.
- Status FSM, states EMPTY, PARTIAL, FULL:
  - EMPTY -> PARTIAL on an accepted write.
  - PARTIAL -> FULL when count==DEPTH-1 and a write is accepted without a read.
  - PARTIAL -> EMPTY when count==1 and a read is accepted without a write.
  - FULL -> PARTIAL on an accepted read.
  - Any other case holds the current state.
- full = (state==FULL) and empty = (state==EMPTY). Both are registered, with no combinational path from inputs.
- Simultaneous read and write:
  - PARTIAL: both are accepted; count and state are unchanged.
  - EMPTY: only the write is accepted; underflow pulses.
  - FULL: only the read is accepted; write data is dropped and overflow pulses.
- almost_full, almost_empty, overflow and underflow are registered and reflect the post-edge count.
- Memory is not reset. Reset clears pointers, count and state only.

## Timing
- Reset values: data_out=0, valid=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, state=EMPTY.
- Reset asserted mid-operation clears everything immediately (asynchronous); stored data is lost. The first access is accepted on the first rising edge after reset deasserts.
- Write-to-flag latency: empty deasserts and count increments in the cycle after the write edge.
- Standard read latency: data_out and valid are updated at the accept edge, 1 cycle after rd_en is presented. valid is high for exactly one cycle per accepted read. data_out holds its value otherwise.
- Write-to-read: a word written at edge N is readable by a request presented in cycle N+1.
- overflow and underflow are high for exactly the cycle following the offending edge.

## Configuration
- FIFO_FWFT_EN defined (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally, with valid = !empty.
  - rd_en acts as a pop acknowledge; read latency is 0.
  - data_out reset value is don't-care while valid=0.
- FIFO_FWFT_EN undefined: the registered-output behaviour in Timing applies.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then write 0x11,0x22,0x33, then read 3 times -> data_out 0x11,0x22,0x33 each one cycle after rd_en, valid pulsing; empty=1 and count=0 after the last read.
- DEPTH=8: write 8 words -> full=1, count=8 and almost_full=1 after the 7th write (AF_LVL=7). A 9th write pulses overflow; subsequent reads show no data corruption.
- Read on empty after reset -> underflow pulses 1 cycle; valid stays 0; count stays 0.
- Fill to 4 entries, then assert wr_en and rd_en together for 20 cycles -> count stays 4; output order matches input order across pointer wrap.
- With full=1, assert wr_en+rd_en together -> one read accepted, overflow pulses, count=7. With empty=1, assert both -> write accepted, underflow pulses, count=1.
- Assert reset asynchronously mid-burst, between edges, with count=5 -> all outputs return to reset values before the next edge. Build with FIFO_FWFT_EN: the first written word appears on data_out with valid=1 in the cycle after its write.
